// File: rtl/imsic_pkg.sv
// Shared IMSIC CSR channel definitions: master FSM states, indirect CSR offsets,
// channel op codes and the topei id field bounds.
package imsic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } imsic_mst_st_e;

   localparam logic [11:0] EIP0_OFF        = 12'h080;
   localparam logic [11:0] EIE0_OFF        = 12'h0C0;
   localparam logic [11:0] EIDELIVERY_OFF  = 12'h070;
   localparam logic [11:0] EITHRESHOLD_OFF = 12'h072;

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_RW  = 2'b01;
   localparam logic [1:0] OP_SET = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   localparam int unsigned TOPEI_ID_LO = 16;
   localparam int unsigned TOPEI_ID_HI = 26;
   localparam int unsigned TOPEI_ID_W  = TOPEI_ID_HI - TOPEI_ID_LO + 1;

endpackage

// File: rtl/imsic_claim_decode.sv
// Maps a topei interrupt id to the eip register address and bit mask that
// clears it; eip registers are XLEN wide, so the split depends on XLEN.
module imsic_claim_decode
   import imsic_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [TOPEI_ID_W-1:0] id,
   output logic [11:0]           addr,
   output logic [XLEN-1:0]       mask
);

   generate
      if (XLEN == 64) begin : g_x64
         // 64-bit eip registers occupy even offsets only
         assign addr = EIP0_OFF + {6'd0, id[10:6], 1'b0};
         assign mask = XLEN'(1) << id[5:0];
      end else begin : g_x32
         assign addr = EIP0_OFF + {6'd0, id[10:5]};
         assign mask = XLEN'(1) << id[4:0];
      end
   endgenerate

endmodule

// File: rtl/imsic_csr_master.sv
// Hart-side IMSIC CSR channel initiator: one request in flight, topei claims
// become a CSRRC of the eip bit. Define IMSIC_CSR_MST_TIMEOUT_EN for a response timeout.
module imsic_csr_master
   import imsic_pkg::*;
#(
   parameter int NR_INTP_FILES   = 7,
   parameter int XLEN            = 64,
   parameter int INTP_FILE_WIDTH = 3,
   parameter int TIMEOUT         = 15
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_vld,
   output logic                          req_rdy,
   input  logic [11:0]                   req_addr,
   input  logic [INTP_FILE_WIDTH-1:0]    req_file,
   input  logic                          req_v,
   input  logic [1:0]                    req_op,
   input  logic [XLEN-1:0]               req_wdata,
   input  logic                          req_priv_illegal,
   input  logic                          req_claim,
   input  logic [32*NR_INTP_FILES-1:0]   xtopei,
   output logic                          rsp_vld,
   input  logic                          rsp_rdy,
   output logic [XLEN-1:0]               rsp_rdata,
   output logic                          rsp_illegal,
   output logic [11:0]                   csr_addr,
   output logic                          csr_rd,
   output logic [INTP_FILE_WIDTH-1:0]    intp_file_sel,
   output logic                          priv_is_illegal,
   output logic                          o_csr_wdata_vld,
   output logic                          o_csr_v,
   output logic [XLEN-1:0]               o_csr_wdata,
   output logic [1:0]                    o_csr_wdata_op,
   input  logic                          i_csr_rdata_vld,
   input  logic [XLEN-1:0]               i_csr_rdata,
   input  logic                          i_csr_illegal
);

   imsic_mst_st_e         state;
   logic                  claim_q;
   logic [31:0]           topei_q;
   logic [31:0]           sel_topei;
   logic [TOPEI_ID_W-1:0] claim_id;
   logic [11:0]           claim_addr;
   logic [XLEN-1:0]       claim_mask;

`ifdef IMSIC_CSR_MST_TIMEOUT_EN
   localparam logic [3:0] TMO_LIM = 4'(TIMEOUT);
   logic [3:0]            tmo_cnt;
`endif

   // Files beyond NR_INTP_FILES read as topei 0, i.e. nothing to claim
   always_comb begin
      sel_topei = '0;
      for (int unsigned i = 0; i < NR_INTP_FILES; i++) begin
         if (req_file == INTP_FILE_WIDTH'(i)) sel_topei = xtopei[i*32 +: 32];
      end
   end

   assign claim_id = sel_topei[TOPEI_ID_HI:TOPEI_ID_LO];

   imsic_claim_decode #(.XLEN(XLEN)) u_claim_decode (
      .id   (claim_id),
      .addr (claim_addr),
      .mask (claim_mask)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         req_rdy         <= 1'b0;
         claim_q         <= 1'b0;
         topei_q         <= '0;
         rsp_vld         <= 1'b0;
         rsp_rdata       <= '0;
         rsp_illegal     <= 1'b0;
         csr_addr        <= '0;
         csr_rd          <= 1'b0;
         intp_file_sel   <= '0;
         priv_is_illegal <= 1'b0;
         o_csr_wdata_vld <= 1'b0;
         o_csr_v         <= 1'b0;
         o_csr_wdata     <= '0;
         o_csr_wdata_op  <= '0;
`ifdef IMSIC_CSR_MST_TIMEOUT_EN
         tmo_cnt         <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               req_rdy <= 1'b1;
               if (req_vld && req_rdy) begin
                  req_rdy <= 1'b0;
                  claim_q <= req_claim;
                  topei_q <= sel_topei;
                  if (req_claim && claim_id == '0) begin
                     state       <= ST_RESP;
                     rsp_vld     <= 1'b1;
                     rsp_rdata   <= '0;
                     rsp_illegal <= 1'b0;
                  end else begin
                     state           <= ST_ISSUE;
                     csr_rd          <= 1'b1;
                     intp_file_sel   <= req_file;
                     priv_is_illegal <= req_priv_illegal;
                     o_csr_v         <= req_v;
                     if (req_claim) begin
                        csr_addr        <= claim_addr;
                        o_csr_wdata     <= claim_mask;
                        o_csr_wdata_op  <= OP_CLR;
                        o_csr_wdata_vld <= 1'b1;
                     end else begin
                        csr_addr        <= req_addr;
                        o_csr_wdata     <= (req_op == OP_RD) ? '0 : req_wdata;
                        o_csr_wdata_op  <= req_op;
                        o_csr_wdata_vld <= (req_op != OP_RD);
                     end
                  end
               end
            end
            ST_ISSUE: begin
               state           <= ST_WAIT;
               csr_addr        <= '0;
               csr_rd          <= 1'b0;
               intp_file_sel   <= '0;
               priv_is_illegal <= 1'b0;
               o_csr_wdata_vld <= 1'b0;
               o_csr_v         <= 1'b0;
               o_csr_wdata     <= '0;
               o_csr_wdata_op  <= '0;
`ifdef IMSIC_CSR_MST_TIMEOUT_EN
               tmo_cnt         <= '0;
`endif
            end
            ST_WAIT: begin
               if (i_csr_rdata_vld) begin
                  state       <= ST_RESP;
                  rsp_vld     <= 1'b1;
                  rsp_illegal <= i_csr_illegal;
                  rsp_rdata   <= claim_q ? XLEN'(topei_q) : i_csr_rdata;
               end
`ifdef IMSIC_CSR_MST_TIMEOUT_EN
               else if (tmo_cnt == TMO_LIM) begin
                  state       <= ST_RESP;
                  rsp_vld     <= 1'b1;
                  rsp_illegal <= 1'b1;
                  rsp_rdata   <= '0;
               end else if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + 4'd1;
               end
`endif
            end
            ST_RESP: begin
               if (rsp_rdy) begin
                  state       <= ST_IDLE;
                  rsp_vld     <= 1'b0;
                  rsp_rdata   <= '0;
                  rsp_illegal <= 1'b0;
                  req_rdy     <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/imsic_csr_master.md
# imsic_csr_master

Hart-side initiator for the IMSIC CSR channel. It accepts one indirect-CSR request at a time from the hart CSR unit (siselect/sireg style accesses or a topei claim). It drives a single-cycle access strobe on the IMSIC CSR channel, waits for the registered read-data/illegal response, and returns the result on a valid/ready response port. A topei claim is turned into a read-clear (CSRRC) of the matching eip bit.

## Interface
Parameters:
- NR_INTP_FILES, 7, number of interrupt files (m, s, vs…)
- XLEN, 64, data width; 32 or 64 only
- INTP_FILE_WIDTH, 3, width of file select
- TIMEOUT, 15, cycles to wait for response before forcing illegal

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_vld  in  1  request valid
- req_rdy  out  1  request ready; high only in IDLE
- req_addr  in  12  indirect CSR address
- req_file  in  INTP_FILE_WIDTH  target interrupt file
- req_v  in  1  request from virtual mode
- req_op  in  2  00 read, 01 rw, 10 set, 11 clr
- req_wdata  in  XLEN  write operand
- req_priv_illegal  in  1  privilege check failed
- req_claim  in  1  topei write (claim); req_op and req_addr ignored
- xtopei  in  32 x NR_INTP_FILES  per-file topei from IMSIC; id in [26:16]
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response accepted
- rsp_rdata  out  XLEN  read data
- rsp_illegal  out  1  access illegal
- csr_addr  out  12  channel address
- csr_rd  out  1  access strobe, exactly one cycle per access
- intp_file_sel  out  INTP_FILE_WIDTH  channel file select
- priv_is_illegal  out  1  forwarded privilege fault
- o_csr_wdata_vld  out  1  access is a write; only with csr_rd
- o_csr_v  out  1  virtual mode
- o_csr_wdata  out  XLEN  write operand
- o_csr_wdata_op  out  2  01/10/11; never 00 with o_csr_wdata_vld
- i_csr_rdata_vld  in  1  channel response strobe
- i_csr_rdata  in  XLEN  channel read data
- i_csr_illegal  in  1  channel illegal, same cycle as i_csr_rdata_vld

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_rdy=1. On req_vld, capture all request fields and go to ISSUE. For a claim with a captured topei id of 0, go directly to RESP with rdata=0 and illegal=0.
- Read (req_op 00): csr_rd=1, o_csr_wdata_vld=0.
- Write (req_op 01/10/11): csr_rd=1, o_csr_wdata_vld=1, o_csr_wdata_op=req_op.
- Claim: id = xtopei[req_file][26:16], captured at accept.
  - XLEN 64: csr_addr = 0x80 + 2*(id>>6); wdata = 1<<id[5:0].
  - XLEN 32: csr_addr = 0x80 + (id>>5); wdata = 1<<id[4:0].
  - op = 11 (CLR). rsp_rdata = captured topei zero-extended, which is the old-value semantics.
- ISSUE: drive the strobe for one cycle, then go to WAIT. All channel outputs are registered and return to 0 after ISSUE.
- WAIT: on i_csr_rdata_vld, latch i_csr_rdata and i_csr_illegal, then go to RESP. For a claim, keep the latched topei as rdata and take illegal from the channel.
- RESP: rsp_vld=1, held with stable data until rsp_rdy, then go to IDLE.
- i_csr_rdata_vld outside WAIT is ignored.

## Timing
- Reset values: every output is 0, including req_rdy. req_rdy rises the first cycle after rst deasserts. FSM is in IDLE.
- Accept at cycle N. csr_rd is high at N+1. Channel response arrives at N+2. rsp_vld is high at N+3.
- Zero-id claim: rsp_vld at N+1.
- rsp_vld and rsp_rdy high together in the same cycle: response completes; req_rdy is high the next cycle. Back-to-back issue rate is one request per 4 cycles.
- rst asserted mid-transaction: abort immediately to IDLE; the in-flight response is dropped.
- Timeout counter: 4 bits, cleared on entry to WAIT, saturates. A late response after timeout is ignored.

## Configuration
- IMSIC_CSR_MST_TIMEOUT_EN defined: when the WAIT count reaches TIMEOUT, go to RESP with rsp_illegal=1 and rsp_rdata=0.
- Macro undefined: no counter; WAIT persists until i_csr_rdata_vld.

## Structure
- Shared package imsic_pkg holds:
  - state enum imsic_mst_st_e
  - CSR offset constants EIP0_OFF=0x80, EIE0_OFF=0xC0, EIDELIVERY_OFF=0x70, EITHRESHOLD_OFF=0x72
  - op codes OP_RD/OP_RW/OP_SET/OP_CLR
  - topei id field bounds
- Sub-module imsic_claim_decode: combinational id→(addr, mask) for both XLEN values.

## Test plan
- Read eithreshold (addr 0x72, file 1), channel returns 0x5 → csr_rd pulse with wdata_vld=0 at N+1; rsp_vld at N+3 with rdata=0x5, illegal=0.
- Set eie0 (addr 0xC0, op 10, wdata 0x30) → wdata_vld=1, op=10, wdata=0x30 during the single csr_rd cycle.
- Claim with xtopei[0][26:16]=70, XLEN 64 → csr_addr=0x82, op=11, wdata=1<<6; rsp_rdata=xtopei[0].
- Claim with id 0 → no csr_rd pulse; rsp_vld at N+1 with rdata=0.
- Channel never responds with the macro defined, TIMEOUT=15 → rsp_illegal=1. A stray i_csr_rdata_vld afterwards is ignored.
- rsp_rdy held low for 5 cycles, then rst asserted in RESP → outputs 0 immediately; req_rdy=1 after reset release.
